input_pulse: RTL and testbench

INPUT_PULSE -- requirements
Module: input_pulse

---
 rtl/pvs_pulse_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/input_pulse.sv | 132 +++++++++++++
 tb/tb_input_pulse.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pvs_pulse_pkg.sv
// Shared types for the pulse validation blocks: FSM states, rejection codes
// and the common measurement counter width.
package pvs_pulse_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LONG = 2'd2,
    ST_GAP  = 2'd3
  } pulse_state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_SHORT = 2'b01,
    ERR_LONG  = 2'b10
  } err_code_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous levels into the clk domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/input_pulse.sv
// Measures the width of pulses on an asynchronous input, accepting those within
// [MIN_WIDTH, MAX_WIDTH] and flagging the rest, with a low-time holdoff between pulses.
module input_pulse #(
  parameter int MIN_WIDTH = 15,
  parameter int MAX_WIDTH = 60,
  parameter int HOLDOFF   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        signal_i,
  output logic        pulse_o,
  output logic [15:0] width_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        busy_o
);

  import pvs_pulse_pkg::*;

  localparam logic [CNT_W-1:0] MIN_W  = 16'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] MAX_W  = 16'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] HOLD_W = 16'(HOLDOFF);

  logic s;

  sync_2ff #(
    .WIDTH(1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (signal_i),
    .q    (s)
  );

  pulse_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  err_code_e        err_code_q, err_code_d;
  logic             pulse_q, pulse_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      width_q    <= '0;
      err_code_q <= ERR_NONE;
      pulse_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      width_q    <= width_d;
      err_code_q <= err_code_d;
      pulse_q    <= pulse_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    width_d    = width_q;
    err_code_d = err_code_q;
    pulse_d    = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (s) begin
          cnt_d   = 16'd1;
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (s) begin
          if (cnt_q < MAX_W) begin
            cnt_d = cnt_q + 16'd1;
          end else begin
            // Flag once here; LONG then waits out the rest of the pulse silently.
            err_d      = 1'b1;
            err_code_d = ERR_LONG;
            state_d    = ST_LONG;
          end
        end else begin
          cnt_d   = '0;
          state_d = ST_GAP;
          if (cnt_q >= MIN_W) begin
            pulse_d = 1'b1;
            width_d = cnt_q;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_SHORT;
          end
        end
      end

      ST_LONG: begin
        if (!s) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (s) begin
          // A high sample during holdoff is treated as a glitch and restarts the wait.
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == HOLD_W) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pulse_o    = pulse_q;
  assign err_o      = err_q;
  assign width_o    = width_q;
  assign err_code_o = err_code_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_input_pulse.sv
// Self-checking bench for input_pulse: directed boundary scenarios plus randomized
// pulses compared against a width-classification model.
module tb_input_pulse;

  localparam int MIN_W = 15;
  localparam int MAX_W = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        signal_i = 1'b0;
  logic        pulse_o;
  logic [15:0] width_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic        busy_o;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int both_cnt = 0;
  int last_width = 0;
  int last_code = 0;

  int pw_q[$];
  int pc_q[$];
  int ecode_q[$];
  int ecyc_q[$];

  input_pulse dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .signal_i  (signal_i),
    .pulse_o   (pulse_o),
    .width_o   (width_o),
    .err_o     (err_o),
    .err_code_o(err_code_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with the cycle it was observed in.
  always @(negedge clk) begin
    if (pulse_o) begin
      pw_q.push_back(int'(width_o));
      pc_q.push_back(cyc);
    end
    if (err_o) begin
      ecode_q.push_back(int'(err_code_o));
      ecyc_q.push_back(cyc);
    end
    if (pulse_o && err_o) both_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required finish before 2ms");
    $fatal(1);
  end

  task automatic clear_events();
    pw_q.delete();
    pc_q.delete();
    ecode_q.delete();
    ecyc_q.delete();
  endtask

  // Drive n high cycles then g low cycles; returns cycle stamps of rise and fall.
  task automatic drive_pulse(input int n, input int g, output int rise, output int fall);
    @(negedge clk);
    signal_i = 1'b1;
    rise = cyc;
    repeat (n) @(negedge clk);
    signal_i = 1'b0;
    fall = cyc;
    repeat (g) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    signal_i = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (pulse_o !== 1'b0) $display("FAIL reset_pulse: got %b want 0", pulse_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else n_pass++;
    n_total++; if (width_o !== 16'd0) $display("FAIL reset_width: got %0d want 0", width_o); else n_pass++;
    n_total++; if (err_code_o !== 2'b00) $display("FAIL reset_code: got %b want 00", err_code_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (busy_o !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy_o); else n_pass++;
    last_width = 0;
    last_code = 0;
    $display("reset: outputs checked in and after reset");
  endtask

  task automatic test_min_width();
    int rise, fall;
    clear_events();
    drive_pulse(MIN_W, 8, rise, fall);
    n_total++; if (pc_q.size() !== 1) $display("FAIL min_pulse_count: got %0d want 1", pc_q.size()); else n_pass++;
    n_total++; if (ecode_q.size() !== 0) $display("FAIL min_err_count: got %0d want 0", ecode_q.size()); else n_pass++;
    if (pc_q.size() > 0) begin
      n_total++; if (pw_q[0] !== MIN_W) $display("FAIL min_width: got %0d want %0d", pw_q[0], MIN_W); else n_pass++;
      n_total++; if (pc_q[0] !== fall + 3) $display("FAIL min_latency: got cycle %0d want %0d", pc_q[0], fall + 3); else n_pass++;
    end
    last_width = MIN_W;
    $display("min_width: high %0d cycles, pulses=%0d errs=%0d", MIN_W, pc_q.size(), ecode_q.size());
  endtask

  task automatic test_short();
    int rise, fall;
    clear_events();
    drive_pulse(MIN_W - 1, 8, rise, fall);
    n_total++; if (pc_q.size() !== 0) $display("FAIL short_pulse_count: got %0d want 0", pc_q.size()); else n_pass++;
    n_total++; if (ecode_q.size() !== 1) $display("FAIL short_err_count: got %0d want 1", ecode_q.size()); else n_pass++;
    if (ecode_q.size() > 0) begin
      n_total++; if (ecode_q[0] !== 1) $display("FAIL short_code: got %0d want 1", ecode_q[0]); else n_pass++;
      n_total++; if (ecyc_q[0] !== fall + 3) $display("FAIL short_latency: got cycle %0d want %0d", ecyc_q[0], fall + 3); else n_pass++;
    end
    n_total++; if (int'(width_o) !== last_width) $display("FAIL short_width_held: got %0d want %0d", width_o, last_width); else n_pass++;
    last_code = 1;
    $display("short: high %0d cycles, pulses=%0d errs=%0d", MIN_W - 1, pc_q.size(), ecode_q.size());
  endtask

  task automatic test_max_and_long();
    int rise, fall;
    clear_events();
    drive_pulse(MAX_W, 8, rise, fall);
    n_total++; if (pc_q.size() !== 1) $display("FAIL max_pulse_count: got %0d want 1", pc_q.size()); else n_pass++;
    n_total++; if (ecode_q.size() !== 0) $display("FAIL max_err_count: got %0d want 0", ecode_q.size()); else n_pass++;
    if (pc_q.size() > 0) begin
      n_total++; if (pw_q[0] !== MAX_W) $display("FAIL max_width: got %0d want %0d", pw_q[0], MAX_W); else n_pass++;
    end
    n_total++; if (int'(err_code_o) !== last_code) $display("FAIL max_code_held: got %0d want %0d", err_code_o, last_code); else n_pass++;
    last_width = MAX_W;
    $display("max_width: high %0d cycles, pulses=%0d errs=%0d", MAX_W, pc_q.size(), ecode_q.size());

    clear_events();
    drive_pulse(100, 8, rise, fall);
    n_total++; if (pc_q.size() !== 0) $display("FAIL long_pulse_count: got %0d want 0", pc_q.size()); else n_pass++;
    n_total++; if (ecode_q.size() !== 1) $display("FAIL long_err_count: got %0d want 1", ecode_q.size()); else n_pass++;
    if (ecode_q.size() > 0) begin
      n_total++; if (ecode_q[0] !== 2) $display("FAIL long_code: got %0d want 2", ecode_q[0]); else n_pass++;
      n_total++; if (ecyc_q[0] !== rise + 2 + MAX_W + 1) $display("FAIL long_timing: got cycle %0d want %0d", ecyc_q[0], rise + 2 + MAX_W + 1); else n_pass++;
    end
    n_total++; if (int'(width_o) !== last_width) $display("FAIL long_width_held: got %0d want %0d", width_o, last_width); else n_pass++;
    last_code = 2;
    $display("too_long: high 100 cycles, pulses=%0d errs=%0d", pc_q.size(), ecode_q.size());
  endtask

  task automatic test_glitch();
    int rise, fall;
    clear_events();
    drive_pulse(20, 2, rise, fall);
    drive_pulse(1, 4, rise, fall);
    drive_pulse(20, 8, rise, fall);
    n_total++; if (pc_q.size() !== 2) $display("FAIL glitch_pulse_count: got %0d want 2", pc_q.size()); else n_pass++;
    n_total++; if (ecode_q.size() !== 0) $display("FAIL glitch_err_count: got %0d want 0", ecode_q.size()); else n_pass++;
    if (pc_q.size() == 2) begin
      n_total++; if (pw_q[1] !== 20) $display("FAIL glitch_width: got %0d want 20", pw_q[1]); else n_pass++;
      n_total++; if (pc_q[1] !== fall + 3) $display("FAIL glitch_latency: got cycle %0d want %0d", pc_q[1], fall + 3); else n_pass++;
    end
    last_width = 20;
    $display("glitch: pulses=%0d errs=%0d", pc_q.size(), ecode_q.size());
  endtask

  task automatic test_reset_abort();
    int rise, fall;
    clear_events();
    @(negedge clk);
    signal_i = 1'b1;
    repeat (10) @(negedge clk);
    n_total++; if (busy_o !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy_o); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if ({pulse_o, err_o, busy_o, err_code_o} !== 5'b0) $display("FAIL abort_strobes: got %b want 00000", {pulse_o, err_o, busy_o, err_code_o}); else n_pass++;
    n_total++; if (width_o !== 16'd0) $display("FAIL abort_width: got %0d want 0", width_o); else n_pass++;
    repeat (20) @(negedge clk);
    signal_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n_total++; if (pc_q.size() + ecode_q.size() !== 0) $display("FAIL abort_no_strobe: got %0d events want 0", pc_q.size() + ecode_q.size()); else n_pass++;
    clear_events();
    drive_pulse(20, 8, rise, fall);
    n_total++; if (pc_q.size() !== 1) $display("FAIL abort_next_count: got %0d want 1", pc_q.size()); else n_pass++;
    if (pc_q.size() > 0) begin
      n_total++; if (pw_q[0] !== 20) $display("FAIL abort_next_width: got %0d want 20", pw_q[0]); else n_pass++;
    end
    last_width = 20;
    last_code = 0;
    $display("reset_abort: next pulse pulses=%0d errs=%0d", pc_q.size(), ecode_q.size());
  endtask

  task automatic test_back_to_back();
    int rise, fall;
    clear_events();
    drive_pulse(MIN_W, 5, rise, fall);
    drive_pulse(MIN_W, 8, rise, fall);
    n_total++; if (pc_q.size() !== 2) $display("FAIL b2b_pulse_count: got %0d want 2", pc_q.size()); else n_pass++;
    if (pc_q.size() == 2) begin
      n_total++; if (pw_q[0] !== MIN_W || pw_q[1] !== MIN_W) $display("FAIL b2b_width: got %0d,%0d want %0d,%0d", pw_q[0], pw_q[1], MIN_W, MIN_W); else n_pass++;
    end
    n_total++; if (ecode_q.size() !== 0) $display("FAIL b2b_err_count: got %0d want 0", ecode_q.size()); else n_pass++;
    last_width = MIN_W;
    $display("back_to_back: pulses=%0d errs=%0d", pc_q.size(), ecode_q.size());
  endtask

  task automatic test_release_high();
    int fall;
    clear_events();
    @(negedge clk);
    rst_n = 1'b0;
    signal_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    signal_i = 1'b0;
    fall = cyc;
    repeat (8) @(negedge clk);
    n_total++; if (pc_q.size() !== 1) $display("FAIL relhigh_count: got %0d want 1", pc_q.size()); else n_pass++;
    if (pc_q.size() > 0) begin
      n_total++; if (pw_q[0] !== 20) $display("FAIL relhigh_width: got %0d want 20", pw_q[0]); else n_pass++;
      n_total++; if (pc_q[0] !== fall + 3) $display("FAIL relhigh_latency: got cycle %0d want %0d", pc_q[0], fall + 3); else n_pass++;
    end
    last_width = 20;
    last_code = 0;
    $display("release_high: pulses=%0d errs=%0d", pc_q.size(), ecode_q.size());
  endtask

  // Model: a pulse of n high cycles is accepted iff MIN_W <= n <= MAX_W; shorter ones
  // are flagged at the same latency as acceptance, longer ones on the (MAX_W+1)th high sample.
  task automatic test_random();
    int rise, fall, n, g, exp_p, exp_e, exp_code, exp_cyc;
    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(1, 80);
      g = $urandom_range(5, 12);
      clear_events();
      drive_pulse(n, g, rise, fall);
      exp_p = (n >= MIN_W && n <= MAX_W) ? 1 : 0;
      exp_e = 1 - exp_p;
      exp_code = (n < MIN_W) ? 1 : 2;
      exp_cyc = (n > MAX_W) ? rise + 2 + MAX_W + 1 : fall + 3;
      n_total++; if (pc_q.size() !== exp_p || ecode_q.size() !== exp_e)
        $display("FAIL rand_counts n=%0d: got p=%0d e=%0d want p=%0d e=%0d", n, pc_q.size(), ecode_q.size(), exp_p, exp_e);
      else n_pass++;
      if (exp_p == 1 && pc_q.size() == 1) begin
        n_total++; if (pw_q[0] !== n || pc_q[0] !== exp_cyc)
          $display("FAIL rand_pulse n=%0d: got width=%0d cyc=%0d want width=%0d cyc=%0d", n, pw_q[0], pc_q[0], n, exp_cyc);
        else n_pass++;
        last_width = n;
      end
      if (exp_e == 1 && ecode_q.size() == 1) begin
        n_total++; if (ecode_q[0] !== exp_code || ecyc_q[0] !== exp_cyc)
          $display("FAIL rand_err n=%0d: got code=%0d cyc=%0d want code=%0d cyc=%0d", n, ecode_q[0], ecyc_q[0], exp_code, exp_cyc);
        else n_pass++;
        last_code = exp_code;
      end
      n_total++; if (int'(width_o) !== last_width || int'(err_code_o) !== last_code)
        $display("FAIL rand_held n=%0d: got width=%0d code=%0d want width=%0d code=%0d", n, width_o, err_code_o, last_width, last_code);
      else n_pass++;
      $display("random[%0d]: n=%0d gap=%0d pulses=%0d errs=%0d", i, n, g, pc_q.size(), ecode_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_min_width();
    test_short();
    test_max_and_long();
    test_glitch();
    test_reset_abort();
    test_back_to_back();
    test_release_high();
    test_random();
    n_total++; if (both_cnt !== 0) $display("FAIL exclusivity: got %0d overlapping cycles want 0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
